// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bus bundle for the write-back register file.
//   Core write port : write_en, write_addr, write_data -> write_ready
//   Host write port : host_we, host_addr, host_wdata (priority on the array)
//   Read ports      : rd_addr_a/b -> rd_data_a/b (combinational, forwarded)
//   Status          : pending, empty, overflow
// The master modport drives requests; the slave modport is the register file.
interface wb_regfile_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          write_ready;

  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;

  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;

  logic [CW-1:0] pending;
  logic          empty;
  logic          overflow;

  modport master (
    output write_en, write_addr, write_data,
    output host_we, host_addr, host_wdata,
    output rd_addr_a, rd_addr_b,
    input  write_ready, rd_data_a, rd_data_b,
    input  pending, empty, overflow
  );

  modport slave (
    input  write_en, write_addr, write_data,
    input  host_we, host_addr, host_wdata,
    input  rd_addr_a, rd_addr_b,
    output write_ready, rd_data_a, rd_data_b,
    output pending, empty, overflow
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file fed by the core through a small
// circular write buffer, draining into a 2^AW x DW register array.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-low reset
//   bus    - wb_regfile_if.slave: core write port (write_en/addr/data,
//            write_ready), host write port (host_we/addr/wdata, wins the
//            array port and stalls the drain), two read ports with
//            forwarding of buffered writes, and pending/empty/overflow.
module wb_regfile #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q   [NREG];
  logic [AW-1:0] baddr_q [DEPTH];
  logic [DW-1:0] bdata_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          ready;
  logic          push;
  logic          pop;
  logic          drop;

  // Handshake is derived from the occupancy register only, so write_ready
  // never depends on this cycle's host_we.
  assign ready = (cnt_q < FULL_CNT);
  assign push  = bus.write_en & ready;
  assign drop  = bus.write_en & ~ready;
  assign pop   = ~bus.host_we & (cnt_q != '0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | drop;
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Buffer payload needs no reset: entries are only observed while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      baddr_q[tail_q] <= bus.write_addr;
      bdata_q[tail_q] <= bus.write_data;
    end
  end

  // Single array write port: host has priority, otherwise drain the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (bus.host_we) begin
      mem_q[bus.host_addr] <= bus.host_wdata;
    end else if (pop) begin
      mem_q[baddr_q[head_q]] <= bdata_q[head_q];
    end
  end

  // Walk the valid entries oldest to youngest so the youngest match wins;
  // fall back to the array when nothing in the buffer targets the address.
  function automatic logic [DW-1:0] fwd_read(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    logic [PW-1:0] idx;
    r = mem_q[a];
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < cnt_q) && (baddr_q[idx] == a)) r = bdata_q[idx];
    end
    return r;
  endfunction

  always_comb begin
    bus.rd_data_a = fwd_read(bus.rd_addr_a);
  end

  always_comb begin
    bus.rd_data_b = fwd_read(bus.rd_addr_b);
  end

  assign bus.write_ready = ready;
  assign bus.pending     = cnt_q;
  assign bus.empty       = (cnt_q == '0);
  assign bus.overflow    = ovf_q;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back register file sitting directly downstream of the `cpu` core. It consumes the core's write port (`write_en`, `write_addr`, `write_data`) through a small write buffer and drains it into a 16 x 8-bit register array. A host/debug port has priority on the array's single write port. Two combinational read ports forward pending buffered writes, so readers always see the architecturally newest value.

## Interface
- `DEPTH`, 4: write-buffer entries; power of two, at least 2.
- `AW`, 4: register address width; the array holds 2^AW entries.
- `DW`, 8: data width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `write_en`  in  1  core write request.
- `write_addr`  in  AW  core write address.
- `write_data`  in  DW  core write data.
- `write_ready`  out  1  buffer can accept a core write this cycle.
- `host_we`  in  1  host write; has priority on the array port.
- `host_addr`  in  AW  host write address.
- `host_wdata`  in  DW  host write data.
- `rd_addr_a`, `rd_addr_b`  in  AW  read addresses.
- `rd_data_a`, `rd_data_b`  out  DW  read data (combinational).
- `pending`  out  log2(DEPTH)+1  number of buffered entries.
- `empty`  out  1  `pending == 0`.
- `overflow`  out  1  sticky flag: a core write was dropped.

## Operation
- **Buffer:** circular FIFO with head/tail pointers that wrap modulo DEPTH, plus an occupancy counter.
- **Push:** occurs when `write_en && write_ready`; stores {addr, data} at the tail.
- **`write_ready`:** equals `pending < DEPTH`. It is registered state only and has no combinational dependence on `host_we`.
- **Dropped write:** `write_en` while full drops the write and sets `overflow`. This holds even if a pop occurs in the same cycle. `overflow` clears only on reset.
- **Pop/drain:** when `!host_we && pending != 0`, the head entry is written to the array and the head advances.
- **Host write:** when `host_we` is high, `host_wdata` is written to `array[host_addr]` and no drain occurs that cycle. Pending entries are not invalidated. A later drain to the same address overwrites the host value.
- **Simultaneous push and pop:** `pending` is unchanged and both pointers advance.
- **Reads** (per port, independently), in priority order:
  1. The youngest valid buffer entry whose addr matches.
  2. Otherwise `array[rd_addr]`.
- **Read limitations:**
  - The same-cycle `write_en` input is not forwarded.
  - The same-cycle `host_we` input is not forwarded.
- **Arithmetic:** `pending` is full-width and never wraps. Pointer width is log2(DEPTH).
- **Reset state** (asynchronous, reset low):
  - All array entries 0.
  - Buffer empty, `pending` = 0, `empty` = 1.
  - `write_ready` = 1.
  - `overflow` = 0.
  - `rd_data_*` = 0 for all addresses.
- **Reset mid-operation:** all buffered writes are discarded, with no partial drain.

## Timing
- **Push:** an entry pushed at edge N is visible on the read ports immediately after edge N.
- **Drain latency:** an entry pushed at edge N drains at edge N+1 at the earliest. It drains later by one cycle per `host_we` cycle and per older entry ahead of it.
- **Host write:** visible on reads after its edge, unless a matching buffered entry shadows it.
- **Back-to-back core writes:** with no host traffic, the core sustains one write per cycle with `pending` ≤ 1 and never stalls.
- **Full buffer:** with `host_we` held high, the buffer fills after DEPTH pushes. `write_ready` falls in the cycle after the DEPTH-th push edge. It rises in the cycle after the first drain edge once `host_we` drops.
- **Flags:** `pending`, `empty`, `write_ready` and `overflow` are all registered-derived, with no input-to-output combinational paths.

## Test plan
- **Reset:** hold `reset`=0 with random inputs.
  - Required: `rd_data_a/b`=0 for all 16 addresses, `pending`=0, `empty`=1, `write_ready`=1, `overflow`=0.
- **Forwarding:** push (addr 3, 0xA5); read addr 3 on port A in the next cycle.
  - Required: 0xA5 is returned, both while buffered and after the drain, and `pending` returns to 0 within 2 cycles.
- **Youngest-match:** hold `host_we`=1 (addr 0xF); push (5,0x11) then (5,0x22).
  - Required: port B on addr 5 returns 0x22 and `pending`=2.
  - Then drop `host_we`. Required: after 2 drains `array[5]`=0x22 and `empty`=1.
- **Full/overflow:** hold `host_we`=1; push DEPTH+1 writes.
  - Required: `write_ready` falls after the 4th push, the 5th write is dropped, `overflow`=1 and stays 1.
  - Then release `host_we`. Required: 4 drains occur in order and `overflow` remains 1.
- **Host/drain ordering:** buffer (7,0x33) while `host_we`=1 targets (7,0x44).
  - Required: reads return 0x33 throughout, and after the drain `array[7]`=0x33.
- **Reset mid-drain:** with 3 entries pending, assert `reset` between edges.
  - Required: outputs go to reset values immediately, and no buffered data reaches the array.
